// File: rtl/me_seq_ctrl_pkg.sv
// rtl/me_seq_ctrl_pkg.sv - shared types and constants for the modexp sequencer
package me_pkg;

    localparam int W_DEF      = 256;
    localparam int E_BITS_DEF = 256;

    localparam logic [W_DEF-1:0] ONE = W_DEF'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHK      = 3'd1,
        MUL_REQ  = 3'd2,
        MUL_WAIT = 3'd3,
        SQR_REQ  = 3'd4,
        SQR_WAIT = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/me_seq_ctrl_if.sv
// rtl/me_seq_ctrl_if.sv - start/done handshake bus between sequencer and modular multiplier
interface me_seq_ctrl_if #(
    parameter int W = 256
);
    logic         mm_start;
    logic [W-1:0] mm_a;
    logic [W-1:0] mm_b;
    logic         mm_done;
    logic [W-1:0] mm_p;

    modport master (
        output mm_start,
        output mm_a,
        output mm_b,
        input  mm_done,
        input  mm_p
    );

    modport slave (
        input  mm_start,
        input  mm_a,
        input  mm_b,
        output mm_done,
        output mm_p
    );
endinterface

// File: rtl/me_seq_ctrl.sv
// rtl/me_seq_ctrl.sv - right-to-left modular exponentiation sequencer over a shared multiplier
module me_seq_ctrl
    import me_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int E_BITS = E_BITS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W-1:0]      m,
    input  logic [E_BITS-1:0] e,
    output logic              ready,
    output logic [W-1:0]      a,
    me_seq_ctrl_if.master     mm
);

    state_t              state_q,    state_d;
    logic                ready_q,    ready_d;
    logic [W-1:0]        a_q,        a_d;
    logic [W-1:0]        s_q,        s_d;
    logic [E_BITS-1:0]   ebuf_q,     ebuf_d;
    logic                mm_start_q, mm_start_d;
    logic [W-1:0]        mm_a_q,     mm_a_d;
    logic [W-1:0]        mm_b_q,     mm_b_d;

    // Operands and the start pulse are registered one cycle ahead of the *_REQ
    // state, so they are already valid in the cycle mm_start is high and stay
    // untouched until the matching mm_done is taken in the *_WAIT state.
    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        a_d        = a_q;
        s_d        = s_q;
        ebuf_d     = ebuf_q;
        mm_start_d = 1'b0;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = W'(ONE);
                    s_d     = m;
                    ebuf_d  = e;
                    ready_d = 1'b0;
                    state_d = CHK;
                end
            end
            CHK: begin
                if (ebuf_q == '0) begin
                    state_d = DONE;
                end else if (ebuf_q[0]) begin
                    mm_start_d = 1'b1;
                    mm_a_d     = a_q;
                    mm_b_d     = s_q;
                    state_d    = MUL_REQ;
                end else begin
                    mm_start_d = 1'b1;
                    mm_a_d     = s_q;
                    mm_b_d     = s_q;
                    state_d    = SQR_REQ;
                end
            end
            MUL_REQ: begin
                state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mm.mm_done) begin
                    a_d = mm.mm_p;
                    // Last set bit consumed: the square it would feed is never used.
                    if ((ebuf_q >> 1) == '0) begin
                        state_d = DONE;
                    end else begin
                        mm_start_d = 1'b1;
                        mm_a_d     = s_q;
                        mm_b_d     = s_q;
                        state_d    = SQR_REQ;
                    end
                end
            end
            SQR_REQ: begin
                state_d = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (mm.mm_done) begin
                    s_d     = mm.mm_p;
                    ebuf_d  = ebuf_q >> 1;
                    state_d = CHK;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; reset drops straight back to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            a_q        <= '0;
            s_q        <= '0;
            ebuf_q     <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            a_q        <= a_d;
            s_q        <= s_d;
            ebuf_q     <= ebuf_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
        end
    end

    assign ready       = ready_q;
    assign a           = a_q;
    assign mm.mm_start = mm_start_q;
    assign mm.mm_a     = mm_a_q;
    assign mm.mm_b     = mm_b_q;

endmodule

// File: tb/tb_me_seq_ctrl.sv
// tb/tb_me_seq_ctrl.sv - randomized self-checking bench for me_seq_ctrl
module tb_me_seq_ctrl;

    localparam int W  = 256;
    localparam int EB = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  m;
    logic [EB-1:0] e;
    logic          ready;
    logic [W-1:0]  a;

    always #5 clk = ~clk;

    me_seq_ctrl_if #(.W(W)) mif ();

    me_seq_ctrl #(.W(W), .E_BITS(EB)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .m     (m),
        .e     (e),
        .ready (ready),
        .a     (a),
        .mm    (mif)
    );

    logic         model_done  = 1'b0;
    logic [W-1:0] model_p     = '0;
    logic         glitch_done = 1'b0;
    logic [W-1:0] glitch_p    = '0;

    assign mif.mm_done = model_done | glitch_done;
    assign mif.mm_p    = glitch_done ? glitch_p : model_p;

    logic [W-1:0] nmod = 256'd7;
    int           lat = 1;
    int           pulse_cnt = 0;
    int           stab_err = 0;
    bit           model_busy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] n);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        p = p % {{W{1'b0}}, n};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Textbook LSB-first square-and-multiply: one product per set bit, one square
    // per bit position below the top set bit.
    task automatic ref_exp(input logic [W-1:0] mi, input logic [EB-1:0] ei, input logic [W-1:0] n,
                           output logic [W-1:0] r, output int np);
        logic [W-1:0] b;
        int top;
        r   = 256'd1;
        b   = mi;
        np  = 0;
        top = -1;
        for (int i = 0; i < EB; i++) if (ei[i]) top = i;
        for (int i = 0; i <= top; i++) begin
            if (ei[i]) begin
                r = mulmod(r, b, n);
                np++;
            end
            if (i < top) begin
                b = mulmod(b, b, n);
                np++;
            end
        end
    endtask

    // Behavioural multiplier: latches operands on mm_start, answers after lat cycles.
    initial begin : mult_model
        logic [W-1:0] x, y;
        bit aborted;
        forever begin
            if (mif.mm_start === 1'b1 && reset === 1'b1) begin
                model_busy = 1'b1;
                aborted    = 1'b0;
                x = mif.mm_a;
                y = mif.mm_b;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (!reset) aborted = 1'b1;
                    if (reset && !aborted && (mif.mm_a !== x || mif.mm_b !== y)) stab_err++;
                end
                model_p    = mulmod(x, y, nmod);
                model_done = 1'b1;
                @(posedge clk); #1;
                model_done = 1'b0;
                model_busy = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    always @(negedge clk) if (mif.mm_start === 1'b1) pulse_cnt <= pulse_cnt + 1;

    task automatic wait_model_idle();
        int c = 0;
        while (model_busy && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        check("model_idle_timeout", W'(model_busy), '0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] mi, input logic [EB-1:0] ei,
                       input int li, input bit inj_start, input bit inj_glitch,
                       output logic [W-1:0] ao, output int pulses, output int cyc);
        int pbase, sbase;
        wait_model_idle();
        lat   = li;
        pbase = pulse_cnt;
        sbase = stab_err;
        @(posedge clk); #1;
        m = mi; e = ei; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m = rand_w();
        e = rand_w();
        cyc = 1;
        check({tag, "_busy"}, W'(ready), '0);
        if (inj_glitch) begin
            glitch_p    = rand_w();
            glitch_done = 1'b1;
            @(posedge clk); #1;
            glitch_done = 1'b0;
            cyc++;
            check({tag, "_glitch_a"}, a, 256'd1);
        end
        while (!ready && cyc < 30000) begin
            start = (inj_start && (cyc == 8 || cyc == 20));
            if (start) begin
                m = rand_w();
                e = rand_w();
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_timeout"}, W'(cyc >= 30000), '0);
        ao     = a;
        pulses = pulse_cnt - pbase;
        check({tag, "_opnd_stable"}, W'(stab_err - sbase), '0);
    endtask

    initial begin : main
        logic [W-1:0] ao, exp_a, mi;
        logic [EB-1:0] ei;
        int pulses, cyc, exp_np, pbase, c;

        reset = 1'b0;
        start = 1'b0;
        m     = '0;
        e     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", W'(ready), 256'd1);
        check("rst_a", a, '0);
        check("rst_mm_start", W'(mif.mm_start), '0);
        check("rst_mm_a", mif.mm_a, '0);
        check("rst_mm_b", mif.mm_b, '0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        nmod = 256'd7;
        run("e3", 256'd5, 256'd3, 4, 1'b0, 1'b0, ao, pulses, cyc);
        check("e3_a", ao, 256'd6);
        check("e3_pulses", W'(pulses), 256'd3);
        check("e3_ready", W'(ready), 256'd1);

        run("e4", 256'd5, 256'd4, 1, 1'b0, 1'b0, ao, pulses, cyc);
        check("e4_a", ao, 256'd2);
        check("e4_pulses", W'(pulses), 256'd3);

        run("e0", 256'd5, 256'd0, 1, 1'b0, 1'b0, ao, pulses, cyc);
        check("e0_a", ao, 256'd1);
        check("e0_pulses", W'(pulses), '0);
        check("e0_latency", W'(cyc), 256'd3);

        run("e1", 256'd5, 256'd1, 2, 1'b0, 1'b0, ao, pulses, cyc);
        check("e1_a", ao, 256'd5);
        check("e1_pulses", W'(pulses), 256'd1);

        nmod = (256'd1 << 255) - 256'd19;
        ei   = 256'd1 << 255;
        ref_exp(256'd3, ei, nmod, exp_a, exp_np);
        run("ebig", 256'd3, ei, 1, 1'b0, 1'b0, ao, pulses, cyc);
        check("ebig_a", ao, exp_a);
        check("ebig_pulses", W'(pulses), 256'd256);
        check("ebig_ref_np", W'(pulses), W'(exp_np));

        nmod = 256'd7;
        run("proto", 256'd5, 256'd3, 10, 1'b1, 1'b1, ao, pulses, cyc);
        check("proto_a", ao, 256'd6);
        check("proto_pulses", W'(pulses), 256'd3);

        for (int t = 0; t < 5; t++) begin
            nmod = rand_w() | (256'd1 << 255) | 256'd1;
            mi   = rand_w() % nmod;
            ei   = rand_w();
            if (t == 1) ei = ei >> 200;
            if (t == 2) ei = ei | 256'd1;
            ref_exp(mi, ei, nmod, exp_a, exp_np);
            run("rnd", mi, ei, $urandom_range(1, 3), 1'b0, 1'b0, ao, pulses, cyc);
            check("rnd_a", ao, exp_a);
            check("rnd_pulses", W'(pulses), W'(exp_np));
        end

        // Reset during the square wait, then let the stale product arrive.
        nmod = 256'd7;
        wait_model_idle();
        lat   = 10;
        pbase = pulse_cnt;
        @(posedge clk); #1;
        m = 256'd5; e = 256'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while ((pulse_cnt - pbase) < 2 && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        check("rst_mid_reach_sqr", W'(c >= 1000), '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_ready", W'(ready), 256'd1);
        check("rst_mid_a", a, '0);
        check("rst_mid_mm_start", W'(mif.mm_start), '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_model_idle();
        repeat (2) @(posedge clk);
        #1;
        check("late_done_a", a, '0);
        check("late_done_ready", W'(ready), 256'd1);

        run("post_rst", 256'd5, 256'd3, 3, 1'b0, 1'b0, ao, pulses, cyc);
        check("post_rst_a", ao, 256'd6);
        check("post_rst_pulses", W'(pulses), 256'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
